// File: rtl/alg_pkg.sv
// Shared definitions for the pulse measurement block: FSM state encoding and default counter width.
package alg_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

endpackage

// File: rtl/alg_pulse_meas_if.sv
// Signal bundle between the edge-detect stage / downstream control and alg_pulse_meas.
interface alg_pulse_meas_if
    import alg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    // rise/fall are single-cycle strobes with no back-pressure. meas_vld is a one-cycle
    // valid with no ready: period/high_width change only with it and must be taken that cycle.
    logic             en;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_width;
    logic             meas_vld;
    logic             locked;
    logic             sat;
    logic             timeout;
    state_t           state;

    modport master (
        output en, rise, fall,
        input  period, high_width, meas_vld, locked, sat, timeout, state
    );

    modport slave (
        input  en, rise, fall,
        output period, high_width, meas_vld, locked, sat, timeout, state
    );

endinterface

// File: rtl/alg_sat_cnt.sv
// Saturating up-counter with clear and load-1; sat flags an increment attempted at all-ones.
module alg_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] MAX = '1;

    assign sat = inc && !clr && !load1 && (cnt == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= W'(1);
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/alg_pulse_meas.sv
// Period / high-time measurement of a trigger signal from rise/fall strobes.
// Optional rise timeout enabled by defining ALG_PULSE_MEAS_TIMEOUT_EN.
module alg_pulse_meas
    import alg_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter logic [31:0] TIMEOUT_CYC = 32'd100_000_000
) (
    input logic            clk,
    input logic            rst,
    alg_pulse_meas_if.slave bus
);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_per, cnt_hi, hi_lat;
    logic [CNT_W-1:0] period_q, high_width_q;
    logic             meas_vld_q, locked_q, sat_q;
    logic             per_clr, per_load, per_inc, per_sat;
    logic             hi_clr, hi_load, hi_inc, hi_sat;
    logic             hi_capture, meas_done, full_high, to_hit;

    alg_sat_cnt #(.W(CNT_W)) u_per_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (per_clr),
        .load1 (per_load),
        .inc   (per_inc),
        .cnt   (cnt_per),
        .sat   (per_sat)
    );

    alg_sat_cnt #(.W(CNT_W)) u_hi_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (hi_clr),
        .load1 (hi_load),
        .inc   (hi_inc),
        .cnt   (cnt_hi),
        .sat   (hi_sat)
    );

`ifdef ALG_PULSE_MEAS_TIMEOUT_EN
    logic per_at_to;
    assign per_at_to = (64'(cnt_per) == 64'(TIMEOUT_CYC));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        per_clr    = 1'b0;
        per_load   = 1'b0;
        per_inc    = 1'b0;
        hi_clr     = 1'b0;
        hi_load    = 1'b0;
        hi_inc     = 1'b0;
        hi_capture = 1'b0;
        meas_done  = 1'b0;
        full_high  = 1'b0;
        to_hit     = 1'b0;
        if (!bus.en) begin
            state_nxt = IDLE;
            per_clr   = 1'b1;
            hi_clr    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    per_clr   = 1'b1;
                    hi_clr    = 1'b1;
                    state_nxt = ARM;
                end
                ARM: begin
                    if (bus.rise) begin
                        per_load  = 1'b1;
                        hi_load   = 1'b1;
                        state_nxt = HIGH;
                    end else begin
                        per_clr = 1'b1;
                        hi_clr  = 1'b1;
                    end
                end
                HIGH: begin
                    // A rise while still high means the fall was lost: report a full-high period.
                    if (bus.rise) begin
                        meas_done = 1'b1;
                        full_high = 1'b1;
                        per_load  = 1'b1;
                        hi_load   = 1'b1;
`ifdef ALG_PULSE_MEAS_TIMEOUT_EN
                    end else if (per_at_to) begin
                        to_hit    = 1'b1;
                        per_clr   = 1'b1;
                        hi_clr    = 1'b1;
                        state_nxt = ARM;
`endif
                    end else if (bus.fall) begin
                        hi_capture = 1'b1;
                        per_inc    = 1'b1;
                        state_nxt  = LOW;
                    end else begin
                        per_inc = 1'b1;
                        hi_inc  = 1'b1;
                    end
                end
                LOW: begin
                    if (bus.rise) begin
                        meas_done = 1'b1;
                        per_load  = 1'b1;
                        hi_load   = 1'b1;
                        state_nxt = HIGH;
`ifdef ALG_PULSE_MEAS_TIMEOUT_EN
                    end else if (per_at_to) begin
                        to_hit    = 1'b1;
                        per_clr   = 1'b1;
                        hi_clr    = 1'b1;
                        state_nxt = ARM;
`endif
                    end else begin
                        per_inc = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_lat       <= '0;
            period_q     <= '0;
            high_width_q <= '0;
            meas_vld_q   <= 1'b0;
            locked_q     <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            meas_vld_q <= meas_done;
            if (hi_capture) begin
                hi_lat <= cnt_hi;
            end
            if (meas_done) begin
                period_q     <= cnt_per;
                high_width_q <= full_high ? cnt_hi : hi_lat;
            end
            if (!bus.en || (state_q == IDLE) || to_hit) begin
                locked_q <= 1'b0;
            end else if (meas_done) begin
                locked_q <= 1'b1;
            end
            if (state_q == IDLE) begin
                sat_q <= 1'b0;
            end else if (per_sat || hi_sat) begin
                sat_q <= 1'b1;
            end
        end
    end

`ifdef ALG_PULSE_MEAS_TIMEOUT_EN
    logic timeout_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_hit;
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.period     = period_q;
    assign bus.high_width = high_width_q;
    assign bus.meas_vld   = meas_vld_q;
    assign bus.locked     = locked_q;
    assign bus.sat        = sat_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_alg_pulse_meas.sv
// Self-checking bench for alg_pulse_meas: 32-bit instance plus a 4-bit instance for saturation/timeout.
module tb_alg_pulse_meas;
    import alg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   failed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] sb_exp;

    alg_pulse_meas_if #(.CNT_W(32)) bus ();
    alg_pulse_meas_if #(.CNT_W(4))  bus_s ();

    alg_pulse_meas #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alg_pulse_meas #(.CNT_W(4), .TIMEOUT_CYC(32'd12)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: every meas_vld on the wide instance must match the next queued {period, high_width}
    always @(negedge clk) begin
        if (bus.meas_vld === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL sb_unexpected: meas_vld with period=%0d high_width=%0d, required no result",
                         bus.period, bus.high_width);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({bus.period, bus.high_width} !== sb_exp) begin
                    failed++;
                    $display("FAIL sb_result: got period=%0d high_width=%0d, required period=%0d high_width=%0d",
                             bus.period, bus.high_width, sb_exp[63:32], sb_exp[31:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f);
        bus.rise = r;
        bus.fall = f;
        step();
        bus.rise = 1'b0;
        bus.fall = 1'b0;
    endtask

    task automatic drive_s(input logic r, input logic f);
        bus_s.rise = r;
        bus_s.fall = f;
        step();
        bus_s.rise = 1'b0;
        bus_s.fall = 1'b0;
    endtask

    task automatic rearm();
        bus.en = 1'b0;
        step();
        step();
        bus.en = 1'b1;
        step();
    endtask

    // One period starting with a rise; hi = 0 means no fall is driven.
    task automatic run_period(input int per, input int hi, output logic vld_rise, output int vld_other);
        drive(1'b1, 1'b0);
        vld_rise  = bus.meas_vld;
        vld_other = 0;
        for (int k = 1; k < per; k++) begin
            drive(1'b0, (hi > 0) && (k == hi));
            if (bus.meas_vld) vld_other++;
        end
    endtask

    task automatic test_reset();
        bus.en = 1'b0;  bus.rise = 1'b0;  bus.fall = 1'b0;
        bus_s.en = 1'b0; bus_s.rise = 1'b0; bus_s.fall = 1'b0;
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if (bus.period !== 32'd0 || bus.high_width !== 32'd0) begin
            failed++;
            $display("FAIL reset_results: got period=%0d high_width=%0d, required 0/0", bus.period, bus.high_width);
        end
        tests_run++;
        if ({bus.meas_vld, bus.locked, bus.sat, bus.timeout} !== 4'b0000) begin
            failed++;
            $display("FAIL reset_flags: got vld/locked/sat/timeout=%b, required 0000",
                     {bus.meas_vld, bus.locked, bus.sat, bus.timeout});
        end
        tests_run++;
        if (bus.state !== IDLE) begin
            failed++;
            $display("FAIL reset_state: got %0d, required %0d", bus.state, IDLE);
        end
        rst = 1'b0;
        step();
        tests_run++;
        if (bus.state !== IDLE) begin
            failed++;
            $display("FAIL idle_hold: got state %0d with en=0, required %0d", bus.state, IDLE);
        end
    endtask

    task automatic test_basic();
        logic vr;
        int   vo;
        rearm();
        tests_run++;
        if (bus.state !== ARM) begin
            failed++;
            $display("FAIL basic_arm: got state %0d, required %0d", bus.state, ARM);
        end
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1);
        run_period(8, 3, vr, vo);
        tests_run++;
        if (vr !== 1'b0 || vo !== 0) begin
            failed++;
            $display("FAIL basic_first_rise: got vld_rise=%b vld_other=%0d, required 0/0", vr, vo);
        end
        exp_q.push_back({32'd8, 32'd3});
        drive(1'b1, 1'b0);
        tests_run++;
        if (bus.meas_vld !== 1'b1 || bus.locked !== 1'b1 || bus.period !== 32'd8 || bus.high_width !== 32'd3) begin
            failed++;
            $display("FAIL basic_result: got vld=%b locked=%b period=%0d high=%0d, required 1/1/8/3",
                     bus.meas_vld, bus.locked, bus.period, bus.high_width);
        end
    endtask

    task automatic test_back_to_back();
        logic vr;
        int   vo;
        int   vld_total = 0;
        int   other_total = 0;
        rearm();
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) exp_q.push_back({32'd5, 32'd2});
            run_period(5, 2, vr, vo);
            if (vr === 1'b1) vld_total++;
            other_total += vo;
        end
        tests_run++;
        if (vld_total !== 20 || other_total !== 0) begin
            failed++;
            $display("FAIL b2b_count: got %0d on rises and %0d elsewhere, required 20 and 0", vld_total, other_total);
        end
        tests_run++;
        if (bus.period !== 32'd5 || bus.high_width !== 32'd2) begin
            failed++;
            $display("FAIL b2b_result: got period=%0d high=%0d, required 5/2", bus.period, bus.high_width);
        end
    endtask

    task automatic test_no_fall();
        logic vr;
        int   vo;
        rearm();
        run_period(6, 0, vr, vo);
        exp_q.push_back({32'd6, 32'd6});
        drive(1'b1, 1'b0);
        tests_run++;
        if (bus.meas_vld !== 1'b1 || bus.period !== 32'd6 || bus.high_width !== 32'd6) begin
            failed++;
            $display("FAIL no_fall: got vld=%b period=%0d high=%0d, required 1/6/6",
                     bus.meas_vld, bus.period, bus.high_width);
        end
    endtask

    task automatic test_min_period();
        logic vr;
        int   vo;
        rearm();
        run_period(2, 1, vr, vo);
        exp_q.push_back({32'd2, 32'd1});
        drive(1'b1, 1'b0);
        tests_run++;
        if (bus.meas_vld !== 1'b1 || bus.period !== 32'd2 || bus.high_width !== 32'd1) begin
            failed++;
            $display("FAIL min_period: got vld=%b period=%0d high=%0d, required 1/2/1",
                     bus.meas_vld, bus.period, bus.high_width);
        end
    endtask

    task automatic test_en_drop();
        logic vr;
        int   vo;
        rearm();
        run_period(7, 3, vr, vo);
        exp_q.push_back({32'd7, 32'd3});
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        tests_run++;
        if (bus.state !== LOW) begin
            failed++;
            $display("FAIL en_drop_low: got state %0d, required %0d", bus.state, LOW);
        end
        bus.en = 1'b0;
        drive(1'b0, 1'b0);
        tests_run++;
        if (bus.state !== IDLE || bus.locked !== 1'b0) begin
            failed++;
            $display("FAIL en_drop_idle: got state=%0d locked=%b, required %0d/0", bus.state, bus.locked, IDLE);
        end
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        tests_run++;
        if (bus.period !== 32'd7 || bus.high_width !== 32'd3) begin
            failed++;
            $display("FAIL en_drop_hold: got period=%0d high=%0d, required 7/3", bus.period, bus.high_width);
        end
        bus.en = 1'b1;
        drive(1'b0, 1'b0);
        tests_run++;
        if (bus.state !== ARM) begin
            failed++;
            $display("FAIL en_rearm: got state %0d, required %0d", bus.state, ARM);
        end
        run_period(6, 2, vr, vo);
        tests_run++;
        if (vr !== 1'b0 || vo !== 0) begin
            failed++;
            $display("FAIL en_first_rise: got vld_rise=%b vld_other=%0d, required 0/0", vr, vo);
        end
        exp_q.push_back({32'd6, 32'd2});
        drive(1'b1, 1'b0);
        tests_run++;
        if (bus.meas_vld !== 1'b1 || bus.locked !== 1'b1 || bus.period !== 32'd6) begin
            failed++;
            $display("FAIL en_second_rise: got vld=%b locked=%b period=%0d, required 1/1/6",
                     bus.meas_vld, bus.locked, bus.period);
        end
    endtask

    task automatic test_async_reset();
        rearm();
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.period !== 32'd0 || bus.high_width !== 32'd0 || bus.state !== IDLE) begin
            failed++;
            $display("FAIL async_reset: got period=%0d high=%0d state=%0d, required 0/0/%0d",
                     bus.period, bus.high_width, bus.state, IDLE);
        end
        tests_run++;
        if ({bus.meas_vld, bus.locked, bus.sat, bus.timeout} !== 4'b0000) begin
            failed++;
            $display("FAIL async_reset_flags: got %b, required 0000",
                     {bus.meas_vld, bus.locked, bus.sat, bus.timeout});
        end
        #3;
        rst = 1'b0;
        step();
        drive(1'b1, 1'b1);
        tests_run++;
        if (bus.state !== HIGH) begin
            failed++;
            $display("FAIL collide_arm: got state %0d, required %0d", bus.state, HIGH);
        end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0);
        exp_q.push_back({32'd7, 32'd3});
        drive(1'b1, 1'b0);
        tests_run++;
        if (bus.meas_vld !== 1'b1 || bus.high_width !== 32'd3) begin
            failed++;
            $display("FAIL collide_result: got vld=%b high=%0d, required 1/3", bus.meas_vld, bus.high_width);
        end
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0);
        exp_q.push_back({32'd4, 32'd4});
        drive(1'b1, 1'b1);
        tests_run++;
        if (bus.period !== 32'd4 || bus.high_width !== 32'd4 || bus.state !== HIGH) begin
            failed++;
            $display("FAIL collide_high: got period=%0d high=%0d state=%0d, required 4/4/%0d",
                     bus.period, bus.high_width, bus.state, HIGH);
        end
    endtask

    task automatic test_saturation();
        int to_count = 0;
        int to_cycle = -1;
        int vld_mid = 0;
        bus_s.en = 1'b1;
        step();
        drive_s(1'b1, 1'b0);
        drive_s(1'b0, 1'b0);
        drive_s(1'b0, 1'b1);
        drive_s(1'b0, 1'b0);
        drive_s(1'b0, 1'b0);
        drive_s(1'b1, 1'b0);
        tests_run++;
        if (bus_s.meas_vld !== 1'b1 || bus_s.locked !== 1'b1 || bus_s.period !== 4'd5 || bus_s.high_width !== 4'd2) begin
            failed++;
            $display("FAIL small_first: got vld=%b locked=%b period=%0d high=%0d, required 1/1/5/2",
                     bus_s.meas_vld, bus_s.locked, bus_s.period, bus_s.high_width);
        end
        for (int c = 6; c < 25; c++) begin
            drive_s(1'b0, c == 8);
            if (bus_s.meas_vld) vld_mid++;
            if (bus_s.timeout) begin
                to_count++;
                to_cycle = c;
            end
        end
        drive_s(1'b1, 1'b0);
`ifdef ALG_PULSE_MEAS_TIMEOUT_EN
        tests_run++;
        if (to_count !== 1 || to_cycle !== 17) begin
            failed++;
            $display("FAIL timeout_pulse: got %0d pulses last at %0d, required 1 at 17", to_count, to_cycle);
        end
        tests_run++;
        if (bus_s.meas_vld !== 1'b0 || bus_s.locked !== 1'b0 || bus_s.state !== HIGH || bus_s.period !== 4'd5) begin
            failed++;
            $display("FAIL timeout_after: got vld=%b locked=%b state=%0d period=%0d, required 0/0/%0d/5",
                     bus_s.meas_vld, bus_s.locked, bus_s.state, bus_s.period, HIGH);
        end
`else
        tests_run++;
        if (to_count !== 0) begin
            failed++;
            $display("FAIL timeout_tied: got %0d pulses, required 0", to_count);
        end
        tests_run++;
        if (bus_s.meas_vld !== 1'b1 || bus_s.period !== 4'd15 || bus_s.high_width !== 4'd3 || bus_s.sat !== 1'b1) begin
            failed++;
            $display("FAIL saturation: got vld=%b period=%0d high=%0d sat=%b, required 1/15/3/1",
                     bus_s.meas_vld, bus_s.period, bus_s.high_width, bus_s.sat);
        end
`endif
        tests_run++;
        if (vld_mid !== 0) begin
            failed++;
            $display("FAIL small_quiet: got %0d meas_vld between rises, required 0", vld_mid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_no_fall();
        test_min_period();
        test_en_drop();
        test_async_reset();
        test_saturation();
        step();
        step();
        tests_run++;
        if (exp_q.size() !== 0) begin
            failed++;
            $display("FAIL sb_drain: got %0d results still expected, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
